// File: rtl/ma_stage_pkg.sv
// Shared definitions for the memory-access stage: control field layout,
// access size encodings, FSM state type and the byte-enable helper.
package ma_stage_pkg;

    localparam int WB_WIDTH = 4;
    localparam int MA_WIDTH = 5;

    // Bit positions inside the MA control word coming from EXMA.
    localparam int MA_RD      = 4;
    localparam int MA_WR      = 3;
    localparam int MA_SIZE_HI = 2;
    localparam int MA_SIZE_LO = 1;
    localparam int MA_SEXT    = 0;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } ma_state_e;

    // Byte lanes touched by an access; size 11 falls into the word case.
    function automatic logic [3:0] calc_be(input logic [1:0] addr_lo, input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 4'b0001 << addr_lo;
            SIZE_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
            default:   return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ma_stage_load_align.sv
// Picks the addressed lane out of a read word and zero- or sign-extends it.
module ma_load_align
    import ma_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       addr_lo,
    input  logic [1:0]       size,
    input  logic             sext,
    input  logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] result
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane select followed by extension according to access size.
    always_comb begin
        byte_v = rdata[{addr_lo, 3'b000} +: 8];
        half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SIZE_BYTE: result = {{(WIDTH-8){sext & byte_v[7]}}, byte_v};
            SIZE_HALF: result = {{(WIDTH-16){sext & half_v[15]}}, half_v};
            default:   result = rdata;
        endcase
    end

endmodule

// File: rtl/ma_stage.sv
// Memory-access stage: issues data-memory transactions for loads/stores,
// stalls the pipe while one is outstanding, and produces the MAWB register.
//
// Memory handshake: o_dmem_req is held high with address, we, be and wdata
// stable from the first BUSY cycle until the cycle i_dmem_ack is high; the
// transaction completes in that cycle, and i_dmem_rdata / i_dmem_err are only
// meaningful alongside ack. A request is never withdrawn early except by reset.
module ma_stage
    import ma_stage_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int RDS_W = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WB_WIDTH-1:0] i_WB_Ctrl,
    input  logic [MA_WIDTH-1:0] i_MEM_Ctrl,
    input  logic                i_Valid,
    input  logic [WIDTH-1:0]    i_ALU_rslt,
    input  logic [WIDTH-1:0]    i_Rs2_val,
    input  logic [WIDTH-1:0]    i_PC,
    input  logic [RDS_W-1:0]    i_Rds_addr,
    input  logic                i_MAWB_flush,
    input  logic                i_MAWB_stall,
    output logic                o_dmem_req,
    output logic                o_dmem_we,
    output logic [WIDTH-1:0]    o_dmem_addr,
    output logic [WIDTH-1:0]    o_dmem_wdata,
    output logic [3:0]          o_dmem_be,
    input  logic                i_dmem_ack,
    input  logic [WIDTH-1:0]    i_dmem_rdata,
    input  logic                i_dmem_err,
    output logic                o_MA_stall,
    output logic                o_misalign,
    output logic                o_bus_err,
    output logic [WIDTH-1:0]    o_Data_To_EX,
    output logic [WB_WIDTH-1:0] o_MAWB_WB,
    output logic [WIDTH-1:0]    o_MAWB_Rslt,
    output logic [RDS_W-1:0]    o_MAWB_Rds_addr,
    output logic [WIDTH-1:0]    o_MAWB_PC,
    output ma_state_e           o_state
);

    localparam int MAWB_W = WB_WIDTH + 2*WIDTH + RDS_W;

    ma_state_e           state, state_nx;
    logic [1:0]          size_in;
    logic                mem_op, misaligned, start;
    logic [WIDTH-1:0]    wdata_nx, align_rslt, mem_rslt;
    logic [MAWB_W-1:0]   mawb_nx, mawb_q, hold_q, mem_result;
    logic                discard, flush_pend;

    // Transaction captured on IDLE->BUSY so the bus sees stable values.
    logic [WIDTH-1:0]    txn_addr, txn_wdata, txn_pc;
    logic [3:0]          txn_be;
    logic                txn_we, txn_sext;
    logic [1:0]          txn_size;
    logic [WB_WIDTH-1:0] txn_wb;
    logic [RDS_W-1:0]    txn_rds;

    assign size_in    = i_MEM_Ctrl[MA_SIZE_HI:MA_SIZE_LO];
    assign mem_op     = i_Valid & (i_MEM_Ctrl[MA_RD] | i_MEM_Ctrl[MA_WR]);
    assign misaligned = (size_in == SIZE_HALF) ? i_ALU_rslt[0] :
                        size_in[1]             ? (|i_ALU_rslt[1:0]) : 1'b0;
    assign start      = (state == ST_IDLE) & mem_op & ~misaligned;
    // A flush seen at any point of a BUSY transaction discards its result.
    assign discard    = flush_pend | i_MAWB_flush;

    ma_load_align #(.WIDTH(WIDTH)) u_align (
        .addr_lo (txn_addr[1:0]),
        .size    (txn_size),
        .sext    (txn_sext),
        .rdata   (i_dmem_rdata),
        .result  (align_rslt)
    );

    assign mem_rslt   = txn_we ? '0 : align_rslt;
    assign mem_result = {txn_wb, mem_rslt, txn_rds, txn_pc};

    // Store data replicated across every lane the access could target.
    always_comb begin
        case (size_in)
            SIZE_BYTE: wdata_nx = {(WIDTH/8){i_Rs2_val[7:0]}};
            SIZE_HALF: wdata_nx = {(WIDTH/16){i_Rs2_val[15:0]}};
            default:   wdata_nx = i_Rs2_val;
        endcase
    end

    // Next-state, stall/misalign outputs and the value offered to MAWB.
    always_comb begin
        state_nx   = state;
        o_MA_stall = 1'b0;
        o_misalign = 1'b0;
        mawb_nx    = '0;
        case (state)
            ST_IDLE: begin
                if (mem_op) begin
                    if (misaligned) begin
                        o_misalign = 1'b1;
                    end else begin
                        o_MA_stall = 1'b1;
                        state_nx   = ST_BUSY;
                    end
                end else if (i_Valid) begin
                    mawb_nx = {i_WB_Ctrl, i_ALU_rslt, i_Rds_addr, i_PC};
                end
            end
            ST_BUSY: begin
                o_MA_stall = ~i_dmem_ack;
                if (i_dmem_ack) begin
                    if (!discard && !i_dmem_err) mawb_nx = mem_result;
                    state_nx = i_MAWB_stall ? ST_HOLD : ST_IDLE;
                end
            end
            ST_HOLD: begin
                mawb_nx = hold_q;
                if (!i_MAWB_stall) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Latch the request fields when a transaction starts.
    always_ff @(posedge clk) begin
        if (!reset) begin
            txn_addr  <= '0;
            txn_wdata <= '0;
            txn_pc    <= '0;
            txn_be    <= '0;
            txn_we    <= 1'b0;
            txn_sext  <= 1'b0;
            txn_size  <= '0;
            txn_wb    <= '0;
            txn_rds   <= '0;
        end else if (start) begin
            txn_addr  <= i_ALU_rslt;
            txn_wdata <= wdata_nx;
            txn_pc    <= i_PC;
            txn_be    <= calc_be(i_ALU_rslt[1:0], size_in);
            txn_we    <= i_MEM_Ctrl[MA_WR];
            txn_sext  <= i_MEM_Ctrl[MA_SEXT];
            txn_size  <= size_in;
            txn_wb    <= i_WB_Ctrl;
            txn_rds   <= i_Rds_addr;
        end
    end

    // Remember a flush that arrives before the ack; cleared once BUSY ends.
    always_ff @(posedge clk) begin
        if (!reset || state != ST_BUSY) flush_pend <= 1'b0;
        else if (i_MAWB_flush)          flush_pend <= 1'b1;
    end

    // Hold register parks a completed result while MAWB is stalled.
    always_ff @(posedge clk) begin
        if (!reset)                                               hold_q <= '0;
        else if (state == ST_BUSY && i_dmem_ack && i_MAWB_stall)  hold_q <= mawb_nx;
        else if (state == ST_HOLD && i_MAWB_flush)                hold_q <= '0;
    end

    // MAWB pipeline register: flush beats stall beats load.
    always_ff @(posedge clk) begin
        if (!reset || i_MAWB_flush) mawb_q <= '0;
        else if (!i_MAWB_stall)     mawb_q <= mawb_nx;
    end

    assign {o_MAWB_WB, o_MAWB_Rslt, o_MAWB_Rds_addr, o_MAWB_PC} = mawb_q;

    assign o_dmem_req   = (state == ST_BUSY);
    assign o_dmem_we    = o_dmem_req & txn_we;
    assign o_dmem_be    = o_dmem_req ? txn_be : 4'b0000;
    assign o_dmem_addr  = {txn_addr[WIDTH-1:2], 2'b00};
    assign o_dmem_wdata = txn_wdata;
    assign o_bus_err    = o_dmem_req & i_dmem_ack & i_dmem_err;
    assign o_Data_To_EX = i_ALU_rslt;
    assign o_state      = state;

endmodule
